// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter that shares memory port A between a scalar requester
// (one 12-bit element) and a vector requester (72-bit, six-element bursts).
// Address and modeSel stay put while a read is in flight because the memory
// rotates the q_a lanes according to the address that is currently applied.
module main_memory_arbiter #(
  parameter int ADDR_W = 19,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [11:0]       s_wdata,
  output logic              s_ack,
  output logic              s_rvalid,
  output logic [11:0]       s_rdata,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [LEN_W-1:0]  v_len,
  input  logic [71:0]       v_wdata,
  output logic              v_ack,
  output logic              v_wready,
  output logic              v_rvalid,
  output logic [71:0]       v_rdata,
  output logic              v_last,
  output logic              mem_modeSel,
  output logic [ADDR_W-1:0] mem_address_a,
  output logic [71:0]       mem_data_a,
  output logic              mem_wren,
  input  logic [71:0]       mem_q_a,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WBEAT, RWAIT, RCAP} state_t;

  // Latency counter value in the final waiting cycle before capture.
  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic              own_vec, own_vec_nxt;
  logic              rr_last_vec, rr_nxt;
  logic [ADDR_W-1:0] addr_r, addr_nxt;
  logic [LEN_W-1:0]  len_r, len_nxt;
  logic [LEN_W-1:0]  beat, beat_nxt;
  logic [2:0]        lat, lat_nxt;
  logic              pick_v, pick_s, g_we;
  logic              cap;
  logic              v_last_wr;
  logic              s_vld_p1, v_vld_p1, v_last_p1;
  logic [11:0]       s_rdata_p1;
  logic [71:0]       v_rdata_p1;

  // Each vector beat covers six consecutive elements; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(6);
  endfunction

  // Vector wins a conflict only when the scalar side was granted last.
  assign pick_v = v_req && (!s_req || !rr_last_vec);
  assign pick_s = s_req && !pick_v;
  assign g_we   = pick_v ? v_we : s_we;

  // Next-state logic and all memory-side / handshake outputs.
  always_comb begin
    state_nxt     = state;
    own_vec_nxt   = own_vec;
    rr_nxt        = rr_last_vec;
    addr_nxt      = addr_r;
    len_nxt       = len_r;
    beat_nxt      = beat;
    lat_nxt       = lat;
    mem_modeSel   = 1'b0;
    mem_address_a = '0;
    mem_data_a    = '0;
    mem_wren      = 1'b0;
    s_ack         = 1'b0;
    v_ack         = 1'b0;
    v_wready      = 1'b0;
    v_last_wr     = 1'b0;
    cap           = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (s_req || v_req)) begin
          // Grant cycle doubles as the issue cycle of beat 0.
          rr_nxt        = pick_v;
          own_vec_nxt   = pick_v;
          mem_modeSel   = pick_v;
          mem_address_a = pick_v ? v_addr : s_addr;
          mem_wren      = g_we;
          s_ack         = pick_s;
          v_ack         = pick_v;
          len_nxt       = pick_v ? v_len : '0;
          beat_nxt      = '0;
          lat_nxt       = 3'd1;
          if (g_we) begin
            mem_data_a = pick_v ? v_wdata : {{60{1'b0}}, s_wdata};
            v_wready   = pick_v;
            v_last_wr  = pick_v && (v_len == '0);
            if (pick_v && (v_len != '0)) begin
              state_nxt = WBEAT;
              beat_nxt  = LEN_W'(1);
              addr_nxt  = next_addr(v_addr);
            end
          end else begin
            addr_nxt  = pick_v ? v_addr : s_addr;
            state_nxt = (RD_LAT == 1) ? RCAP : RWAIT;
          end
        end
      end
      WBEAT: begin
        mem_modeSel   = 1'b1;
        mem_address_a = addr_r;
        mem_wren      = 1'b1;
        mem_data_a    = v_wdata;
        v_wready      = 1'b1;
        v_last_wr     = (beat == len_r);
        if (beat == len_r) begin
          state_nxt = IDLE;
        end else begin
          beat_nxt = beat + LEN_W'(1);
          addr_nxt = next_addr(addr_r);
        end
      end
      RWAIT: begin
        mem_modeSel   = own_vec;
        mem_address_a = addr_r;
        if (lat == LAT_LAST) begin
          state_nxt = RCAP;
        end else begin
          lat_nxt = lat + 3'd1;
        end
      end
      RCAP: begin
        mem_modeSel   = own_vec;
        mem_address_a = addr_r;
        cap           = 1'b1;
        if (beat != len_r) begin
          // Next beat is issued in the same cycle its predecessor's rvalid pulses.
          state_nxt = RWAIT;
          beat_nxt  = beat + LEN_W'(1);
          addr_nxt  = next_addr(addr_r);
          lat_nxt   = 3'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      own_vec     <= 1'b0;
      rr_last_vec <= 1'b1;
      addr_r      <= '0;
      len_r       <= '0;
      beat        <= '0;
      lat         <= '0;
    end else begin
      state       <= state_nxt;
      own_vec     <= own_vec_nxt;
      rr_last_vec <= rr_nxt;
      addr_r      <= addr_nxt;
      len_r       <= len_nxt;
      beat        <= beat_nxt;
      lat         <= lat_nxt;
    end
  end

  // Capture stage -> p1: read valid pulses, cleared by reset so nothing pending survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld_p1  <= 1'b0;
      v_vld_p1  <= 1'b0;
      v_last_p1 <= 1'b0;
    end else begin
      s_vld_p1  <= cap && !own_vec;
      v_vld_p1  <= cap && own_vec;
      v_last_p1 <= cap && own_vec && (beat == len_r);
    end
  end

  // Capture stage -> p1: read data, held between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rdata_p1 <= '0;
      v_rdata_p1 <= '0;
    end else if (cap) begin
      if (own_vec) begin
        v_rdata_p1 <= mem_q_a;
      end else begin
        s_rdata_p1 <= mem_q_a[11:0];
      end
    end
  end

  assign s_rvalid = s_vld_p1;
  assign s_rdata  = s_rdata_p1;
  assign v_rvalid = v_vld_p1;
  assign v_rdata  = v_rdata_p1;
  assign v_last   = v_last_wr | v_last_p1;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter: an element-addressed memory model
// behind the RD_LAT=1 instance, plus an RD_LAT=3 instance for latency checks.
module tb_main_memory_arbiter;

  localparam int ADDR_W = 19;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1 (RD_LAT=1)
  logic              s_req, s_we, s_ack, s_rvalid;
  logic [ADDR_W-1:0] s_addr;
  logic [11:0]       s_wdata, s_rdata;
  logic              v_req, v_we, v_ack, v_wready, v_rvalid, v_last;
  logic [ADDR_W-1:0] v_addr;
  logic [LEN_W-1:0]  v_len;
  logic [71:0]       v_wdata, v_rdata;
  logic              m_sel, m_wren, busy;
  logic [ADDR_W-1:0] m_addr;
  logic [71:0]       m_data, m_q;

  // Instance 2 (RD_LAT=3)
  logic              s2_req, s2_we, s2_ack, s2_rvalid;
  logic [ADDR_W-1:0] s2_addr;
  logic [11:0]       s2_wdata, s2_rdata;
  logic              v2_ack, v2_wready, v2_rvalid, v2_last;
  logic [71:0]       v2_rdata;
  logic              m2_sel, m2_wren, busy2;
  logic [ADDR_W-1:0] m2_addr;
  logic [71:0]       m2_data;
  logic [71:0]       q2a, q2b, q2c;

  main_memory_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_len(v_len), .v_wdata(v_wdata),
    .v_ack(v_ack), .v_wready(v_wready), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .v_last(v_last),
    .mem_modeSel(m_sel), .mem_address_a(m_addr), .mem_data_a(m_data),
    .mem_wren(m_wren), .mem_q_a(m_q), .busy(busy)
  );

  main_memory_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .s_req(s2_req), .s_we(s2_we), .s_addr(s2_addr), .s_wdata(s2_wdata),
    .s_ack(s2_ack), .s_rvalid(s2_rvalid), .s_rdata(s2_rdata),
    .v_req(1'b0), .v_we(1'b0), .v_addr('0), .v_len('0), .v_wdata('0),
    .v_ack(v2_ack), .v_wready(v2_wready), .v_rvalid(v2_rvalid), .v_rdata(v2_rdata),
    .v_last(v2_last),
    .mem_modeSel(m2_sel), .mem_address_a(m2_addr), .mem_data_a(m2_data),
    .mem_wren(m2_wren), .mem_q_a(q2c), .busy(busy2)
  );

  // Element-addressed memory with one cycle of read latency.
  logic [11:0] emem [int];
  logic [71:0] qn;
  int          ea;

  function automatic logic [11:0] rd_elem(input int a);
    if (emem.exists(a)) return emem[a];
    return 12'h000;
  endfunction

  always @(posedge clk) begin
    qn = '0;
    if (m_sel) begin
      for (int i = 0; i < 6; i++) qn[12*i +: 12] = rd_elem((int'(m_addr) + i) & 524287);
    end else begin
      qn[11:0] = rd_elem(int'(m_addr));
    end
    if (m_wren) begin
      if (m_sel) begin
        for (int i = 0; i < 6; i++) begin
          ea = (int'(m_addr) + i) & 524287;
          emem[ea] = m_data[12*i +: 12];
        end
      end else begin
        emem[int'(m_addr)] = m_data[11:0];
      end
    end
    m_q <= qn;
  end

  // Three-deep read pipeline for the RD_LAT=3 instance: returns ~addr[11:0].
  always @(posedge clk) begin
    q2a <= {60'd0, m2_addr[11:0] ^ 12'hFFF};
    q2b <= q2a;
    q2c <= q2b;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [71:0] VA = 72'h111222333444555666;
  localparam logic [71:0] VB = 72'hAAABBBCCCDDDEEEFFF;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_len = '0; v_wdata = '0;
    s2_req = 0; s2_we = 0; s2_addr = '0; s2_wdata = '0;
    m_q = '0;
    cyc(); cyc();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wren", m_wren, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_sel", m_sel, 0);
    chk("rst_srdata", s_rdata, 0);
    chk("rst_vrdata", v_rdata, 0);
    chk("rst_rvalid", {s_rvalid, v_rvalid, v_last}, 0);
    rst = 1'b0;
    cyc();

    // 1: scalar write 0xABC @13, then scalar read @13
    s_req = 1; s_we = 1; s_addr = 19'd13; s_wdata = 12'hABC;
    #1;
    chk("t1_wack", s_ack, 1);
    chk("t1_wren", m_wren, 1);
    chk("t1_waddr", m_addr, 13);
    chk("t1_wdata", m_data, 72'hABC);
    chk("t1_wsel", m_sel, 0);
    cyc();
    s_req = 0;
    #1;
    chk("t1_wren_off", m_wren, 0);
    chk("t1_busy_w", busy, 0);
    s_req = 1; s_we = 0;
    #1;
    chk("t1_rack", s_ack, 1);
    chk("t1_rwren", m_wren, 0);
    chk("t1_raddr", m_addr, 13);
    cyc();
    s_req = 0;
    #1;
    chk("t1_hold_addr", m_addr, 13);
    chk("t1_busy_r", busy, 1);
    chk("t1_rvalid_early", s_rvalid, 0);
    cyc();
    chk("t1_rvalid", s_rvalid, 1);
    chk("t1_rdata", s_rdata, 12'hABC);
    chk("t1_busy_done", busy, 0);
    cyc();
    chk("t1_rvalid_pulse", s_rvalid, 0);
    chk("t1_rdata_hold", s_rdata, 12'hABC);

    // 2: vector write A,B @7 len 1, then vector read @7 len 1
    v_req = 1; v_we = 1; v_addr = 19'd7; v_len = 8'd1; v_wdata = VA;
    #1;
    chk("t2_ack", v_ack, 1);
    chk("t2_wready0", v_wready, 1);
    chk("t2_addr0", m_addr, 7);
    chk("t2_data0", m_data, VA);
    chk("t2_sel", m_sel, 1);
    chk("t2_last0", v_last, 0);
    cyc();
    v_req = 0; v_wdata = VB;
    #1;
    chk("t2_ack_pulse", v_ack, 0);
    chk("t2_wready1", v_wready, 1);
    chk("t2_addr1", m_addr, 13);
    chk("t2_data1", m_data, VB);
    chk("t2_last1", v_last, 1);
    cyc();
    chk("t2_wdone", {busy, m_wren}, 0);
    v_req = 1; v_we = 0;
    #1;
    chk("t2_rack", v_ack, 1);
    chk("t2_raddr0", m_addr, 7);
    chk("t2_rwren", m_wren, 0);
    cyc();
    v_req = 0;
    #1;
    chk("t2_rhold0", m_addr, 7);
    chk("t2_rv_early", v_rvalid, 0);
    cyc();
    chk("t2_rv0", v_rvalid, 1);
    chk("t2_rd0", v_rdata, VA);
    chk("t2_rlast0", v_last, 0);
    chk("t2_raddr1", m_addr, 13);
    cyc();
    chk("t2_rv_gap", v_rvalid, 0);
    chk("t2_rhold1", m_addr, 13);
    cyc();
    chk("t2_rv1", v_rvalid, 1);
    chk("t2_rd1", v_rdata, VB);
    chk("t2_rlast1", v_last, 1);
    chk("t2_rbusy", busy, 0);

    // 3: simultaneous requests after reset: S, V, S, V
    rst = 1; cyc(); rst = 0;
    s_req = 1; s_we = 1; s_addr = 19'd100; s_wdata = 12'h123;
    v_req = 1; v_we = 1; v_addr = 19'd200; v_len = 8'd0; v_wdata = VA;
    #1;
    chk("t3_g0", {s_ack, v_ack}, 2'b10);
    cyc();
    chk("t3_g1", {s_ack, v_ack}, 2'b01);
    chk("t3_g1_addr", m_addr, 200);
    chk("t3_g1_last", v_last, 1);
    cyc();
    chk("t3_g2", {s_ack, v_ack}, 2'b10);
    cyc();
    chk("t3_g3", {s_ack, v_ack}, 2'b01);
    cyc();
    s_req = 0; v_req = 0;
    #1;
    chk("t3_idle", {s_ack, v_ack, busy}, 0);

    // 4: vector write len 3 across the address wrap
    v_req = 1; v_we = 1; v_addr = 19'd524286; v_len = 8'd3; v_wdata = VB;
    #1;
    chk("t4_a0", m_addr, 524286);
    chk("t4_w0", {v_wready, v_last}, 2'b10);
    cyc();
    v_req = 0;
    #1;
    chk("t4_a1", m_addr, 4);
    chk("t4_w1", {v_wready, v_last}, 2'b10);
    cyc();
    chk("t4_a2", m_addr, 10);
    chk("t4_w2", {v_wready, v_last}, 2'b10);
    cyc();
    chk("t4_a3", m_addr, 16);
    chk("t4_w3", {v_wready, v_last}, 2'b11);
    cyc();
    chk("t4_done", {v_wready, busy, m_wren}, 0);

    // 5: reset during beat 2 of a len-5 read burst
    v_req = 1; v_we = 0; v_addr = 19'd0; v_len = 8'd5;
    #1;
    chk("t5_ack", v_ack, 1);
    cyc();
    v_req = 0;
    cyc();
    chk("t5_rv0", v_rvalid, 1);
    cyc();
    cyc();
    chk("t5_rv1", v_rvalid, 1);
    chk("t5_addr2", m_addr, 12);
    cyc();
    rst = 1;
    #1;
    chk("t5_busy_pre", busy, 1);
    cyc();
    rst = 0;
    #1;
    chk("t5_busy_post", busy, 0);
    chk("t5_rv_supp", {v_rvalid, v_last}, 0);
    chk("t5_addr_idle", m_addr, 0);
    s_req = 1; s_we = 1; s_addr = 19'd50; s_wdata = 12'h777;
    #1;
    chk("t5_sack", s_ack, 1);
    chk("t5_swren", m_wren, 1);
    cyc();
    s_req = 0;
    #1;
    chk("t5_rv_none1", v_rvalid, 0);
    cyc();
    chk("t5_rv_none2", v_rvalid, 0);

    // 6: RD_LAT=3 scalar read
    s2_req = 1; s2_we = 0; s2_addr = 19'h123;
    #1;
    chk("t6_ack", s2_ack, 1);
    chk("t6_a0", m2_addr, 19'h123);
    cyc();
    s2_req = 0;
    #1;
    chk("t6_a1", m2_addr, 19'h123);
    chk("t6_rv1", s2_rvalid, 0);
    cyc();
    chk("t6_a2", m2_addr, 19'h123);
    chk("t6_rv2", s2_rvalid, 0);
    cyc();
    chk("t6_a3", m2_addr, 19'h123);
    chk("t6_rv3", s2_rvalid, 0);
    chk("t6_busy3", busy2, 1);
    cyc();
    chk("t6_rv4", s2_rvalid, 1);
    chk("t6_rdata", s2_rdata, 12'hEDC);
    chk("t6_a4", m2_addr, 0);
    chk("t6_busy4", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
